// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: ALU shift modes and controller states.
package shifter_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by 0..STEP positions in the given mode.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0]       data,
    input  logic [$clog2(STEP):0]  amt,
    input  logic [1:0]             mode,
    output logic [WIDTH-1:0]       result
);

    logic signed [WIDTH-1:0] data_s;

    assign data_s = data;

    // The reserved mode encoding falls through to a logical left shift.
    always_comb begin
        case (mode)
            MODE_SRL: result = data >> amt;
            MODE_SRA: result = WIDTH'(data_s >>> amt);
            default:  result = data << amt;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter for the ALU path, at most STEP positions per clock,
// with valid/ready handshakes on both sides.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    localparam int AMT_W = $clog2(STEP) + 1;
    localparam logic [SHAMT_W:0] STEP_CAP = (SHAMT_W + 1)'(STEP);

    state_t             state, state_d;
    logic [WIDTH-1:0]   work, work_d, step_out;
    logic [1:0]         mode_q, mode_d;
    logic [SHAMT_W-1:0] remaining, remaining_d;
    logic [SHAMT_W:0]   rem_ext, rem_left;
    logic [AMT_W-1:0]   k;

    // One extra bit so STEP=WIDTH still compares correctly; k never exceeds remaining.
    assign rem_ext  = {1'b0, remaining};
    assign k        = (rem_ext > STEP_CAP) ? AMT_W'(STEP) : AMT_W'(remaining);
    assign rem_left = rem_ext - (SHAMT_W + 1)'(k);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data   (work),
        .amt    (k),
        .mode   (mode_q),
        .result (step_out)
    );

    always_comb begin
        state_d     = state;
        work_d      = work;
        mode_d      = mode_q;
        remaining_d = remaining;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d      = in_data;
                    mode_d      = in_mode;
                    remaining_d = in_shamt;
                    state_d     = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d      = step_out;
                remaining_d = rem_left[SHAMT_W-1:0];
                if (rem_left == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset discards any in-flight operation; out_data reads back as zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work      <= '0;
            mode_q    <= MODE_SLL;
            remaining <= '0;
        end else begin
            state     <= state_d;
            work      <= work_d;
            mode_q    <= mode_d;
            remaining <= remaining_d;
        end
    end

    assign in_ready  = (state == ST_IDLE) && rst_n;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_SHIFT) || (state == ST_DONE);
    assign out_data  = work;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: three instances (STEP=1, 4, 32) share stimulus,
// a reference model fills the expected queue and a monitor pops it on each output transfer.
module tb_seq_shifter;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] in_valid;
    logic [NI-1:0] in_ready;
    logic [31:0]   in_data;
    logic [4:0]    in_shamt;
    logic [1:0]    in_mode;
    logic [NI-1:0] out_valid;
    logic          out_ready;
    logic [31:0]   od [NI];
    logic [NI-1:0] busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];

    logic [NI-1:0] prev_v = '0;
    int            rise_cyc [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_shifter #(.WIDTH(32), .STEP(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(od[0]), .busy(busy[0]));

    seq_shifter #(.WIDTH(32), .STEP(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(od[1]), .busy(busy[1]));

    seq_shifter #(.WIDTH(32), .STEP(32)) dut_s32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(od[2]), .busy(busy[2]));

    function automatic int step_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 32;
        endcase
    endfunction

    // Reference: SRA = logical right shift with the vacated top bits set from the sign.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] m);
        logic [31:0] r;
        if (m == 2'b01) begin
            r = d >> sh;
        end else if (m == 2'b11) begin
            r = d >> sh;
            if (d[31]) r = r | ~(32'hFFFF_FFFF >> sh);
        end else begin
            r = d << sh;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int i, input logic [31:0] d, input int sh, input logic [1:0] m);
        exp_t e;
        e.inst = i;
        e.data = ref_shift(d, sh, m);
        e.lat  = 1 + (sh + step_of(i) - 1) / step_of(i);
        e.acc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input int sh, input logic [1:0] m);
        logic [NI-1:0] pend;
        int guard;
        @(negedge clk);
        in_data  = d;
        in_shamt = 5'(sh);
        in_mode  = m;
        pend     = '1;
        in_valid = pend;
        guard    = 0;
        while (pend != '0 && guard < 400) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (pend[i] && in_ready[i]) begin
                    push_exp(i, d, sh, m);
                    pend[i] = 1'b0;
                end
            end
            @(negedge clk);
            in_valid = pend;
            guard++;
        end
        if (pend != '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: pending %b expected 000", pend);
            in_valid = '0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid != '0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (sb.size() != 0 || out_valid != '0) begin
            n_fail++;
            $display("FAIL drain_timeout: outstanding %0d expected 0", sb.size());
        end
    endtask

    // Monitor: samples a little after the falling edge, once the driver has settled.
    always begin
        int idx;
        @(negedge clk);
        #2;
        for (int i = 0; i < NI; i++) begin
            if (out_valid[i] && !prev_v[i]) rise_cyc[i] = cyc;
            if (out_valid[i] && out_ready) begin
                idx = -1;
                foreach (sb[j]) if (idx < 0 && sb[j].inst == i) idx = j;
                if (idx < 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result step%0d: got %h expected no result", step_of(i), od[i]);
                end else begin
                    check($sformatf("data_step%0d", step_of(i)), od[i], sb[idx].data);
                    check($sformatf("latency_step%0d", step_of(i)),
                          32'(rise_cyc[i] - sb[idx].acc + 1), 32'(sb[idx].lat));
                    sb.delete(idx);
                end
            end
        end
        prev_v = out_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_in_ready", in_ready, 3'b000);
        check("reset_out_valid", out_valid, 3'b000);
        check("reset_busy", busy, 3'b000);
        for (int i = 0; i < NI; i++) check($sformatf("reset_out_data_step%0d", step_of(i)), od[i], 32'h0);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", in_ready, 3'b111);

        out_ready = 1'b1;
        send(32'h0000_0001, 31, 2'b00);
        send(32'h8000_0000, 4, 2'b11);
        send(32'h7FFF_FFF0, 4, 2'b11);
        send(32'h8000_0000, 31, 2'b01);
        send(32'h0000_0001, 3, 2'b10);
        drain();

        // Zero shift under backpressure with in_valid held high.
        out_ready = 1'b0;
        @(negedge clk);
        in_data  = 32'hDEAD_BEEF;
        in_shamt = 5'd0;
        in_mode  = 2'b00;
        in_valid = '1;
        #1;
        check("bp_accept_ready", in_ready, 3'b111);
        for (int i = 0; i < NI; i++) push_exp(i, 32'hDEAD_BEEF, 0, 2'b00);
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_in_ready", in_ready, 3'b000);
            check("bp_out_valid", out_valid, 3'b111);
            check("bp_busy", busy, 3'b111);
            for (int i = 0; i < NI; i++) check($sformatf("bp_hold_step%0d", step_of(i)), od[i], 32'hDEAD_BEEF);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = '0;
        @(negedge clk);
        #1;
        check("bp_ready_after_transfer", in_ready, 3'b111);
        drain();

        // Reset in the middle of a long shift: the request must vanish.
        @(negedge clk);
        in_data  = 32'h0000_0001;
        in_shamt = 5'd20;
        in_mode  = 2'b00;
        in_valid = '1;
        #1;
        check("abort_accept_ready", in_ready, 3'b111);
        @(negedge clk);
        in_valid = '0;
        #1;
        check("abort_busy", busy, 3'b111);
        check("abort_no_valid", out_valid, 3'b000);
        rst_n = 1'b0;
        #1;
        check("abort_ready_in_reset", in_ready, 3'b000);
        @(negedge clk);
        #1;
        check("abort_valid_after_reset", out_valid, 3'b000);
        check("abort_busy_after_reset", busy, 3'b000);
        rst_n = 1'b1;
        #1;
        check("abort_ready_release", in_ready, 3'b111);
        send(32'h0000_0001, 1, 2'b00);
        drain();

        // Sweep every amount in every mode with random operands and random backpressure.
        rand_rdy = 1'b1;
        for (int mi = 0; mi < 4; mi++) begin
            for (int sh = 0; sh < 32; sh++) begin
                send($urandom, sh, 2'(mi));
            end
        end
        rand_rdy = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
